// File: rtl/aes_sbox_engine_if.sv
// Valid/ready transport for one 128-bit AES state into and out of the SubBytes engine.
// The slave modport is the engine's view; master is the producer/consumer side.
interface aes_sbox_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/aes_sbox_engine.sv
// Forward AES SubBytes engine: substitutes a 128-bit state LANES bytes per cycle
// through copies of the FIPS-197 forward S-box, with valid/ready on both sides.
module aes_sbox_engine #(
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst,
   aes_sbox_engine_if.slave bus,
   output logic             busy
);
   localparam int NB = 16 / LANES;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   // Row-major forward table, entry x at bits [2047-8x -: 8].
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_sbox_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[2047 - 8*int'(x) -: 8];
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [127:0]  r_work;
   logic [127:0]  w_work_nxt;
   logic [127:0]  w_sub;
   int            w_base;

   assign w_base = (NB == 1) ? 0 : int'(r_cnt) * LANES;

   // Working register with the current byte group replaced, one lookup per lane.
   always_comb begin
      w_sub = r_work;
      for (int l = 0; l < LANES; l++) begin
         w_sub[127 - 8*(w_base + l) -: 8] = sbox(r_work[127 - 8*(w_base + l) -: 8]);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_work_nxt  = r_work;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_work_nxt  = bus.in_data;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_work_nxt = w_sub;
            if (r_cnt == CW'(NB - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_work  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_work  <= w_work_nxt;
      end
   end

   // out_data stays on the working register, so it holds until the next accept.
   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.out_data  = r_work;
   assign busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_aes_sbox_engine.sv
// Bench for aes_sbox_engine: LANES=4 main instance plus LANES=1/16 instances for latency,
// checked against a forward table rebuilt from the decrypt-side inverse S-box.
module tb_aes_sbox_engine;
   localparam int NB = 4;
   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   localparam logic [2047:0] INV_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_sbox_engine_if m_if ();
   aes_sbox_engine_if a1_if ();
   aes_sbox_engine_if a16_if ();
   logic busy_m, busy_1, busy_16;

   aes_sbox_engine #(.LANES(4))  u_dut  (.clk(clk), .rst(rst), .bus(m_if.slave),   .busy(busy_m));
   aes_sbox_engine #(.LANES(1))  u_l1   (.clk(clk), .rst(rst), .bus(a1_if.slave),  .busy(busy_1));
   aes_sbox_engine #(.LANES(16)) u_l16  (.clk(clk), .rst(rst), .bus(a16_if.slave), .busy(busy_16));

   int n_vec = 0;
   int n_err = 0;
   logic [7:0]   fwd_t [256];
   logic [127:0] d, q, q_m, q_1, q_16, exp_d;
   logic [127:0] blk [3];
   logic [127:0] odat [3];
   int           ocyc [3];
   int           lat, lat_m, lat_1, lat_16, k, nout;
   logic         acc, seen;

   function automatic logic [7:0] inv_b(input logic [7:0] x);
      return INV_TBL[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [127:0] model_sub(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = fwd_t[s[127 - 8*i -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] inv_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_b(s[127 - 8*i -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int expv);
      n_vec++;
      assert (obs == expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Present one block to the LANES=4 instance with out_ready high; returns result and latency.
   task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lt);
      m_if.in_valid  = 1'b1;
      m_if.in_data   = din;
      m_if.out_ready = 1'b1;
      lt   = 0;
      dout = '0;
      for (int c = 1; c <= 40 && lt == 0; c++) begin
         tick();
         m_if.in_valid = 1'b0;
         m_if.in_data  = rnd128();
         if (m_if.out_valid) begin
            lt   = c;
            dout = m_if.out_data;
         end
      end
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) fwd_t[inv_b(8'(i))] = 8'(i);

      rst = 1'b1;
      m_if.in_valid = 1'b0;   m_if.in_data = '0;   m_if.out_ready = 1'b0;
      a1_if.in_valid = 1'b0;  a1_if.in_data = '0;  a1_if.out_ready = 1'b1;
      a16_if.in_valid = 1'b0; a16_if.in_data = '0; a16_if.out_ready = 1'b1;

      // Reset then idle
      tick();
      tick();
      rst = 1'b0;
      chk1("rst_in_ready", m_if.in_ready, 1'b1);
      chk1("rst_out_valid", m_if.out_valid, 1'b0);
      chk1("rst_busy", busy_m, 1'b0);
      chk("rst_out_data", m_if.out_data, '0);
      chk1("rst_in_ready_l1", a1_if.in_ready, 1'b1);
      chk1("rst_in_ready_l16", a16_if.in_ready, 1'b1);
      tick();

      // FIPS-197 Appendix B round-1 SubBytes on all three lane counts
      m_if.in_valid = 1'b1;   m_if.in_data = FIPS_IN;   m_if.out_ready = 1'b1;
      a1_if.in_valid = 1'b1;  a1_if.in_data = FIPS_IN;
      a16_if.in_valid = 1'b1; a16_if.in_data = FIPS_IN;
      lat_m = 0; lat_1 = 0; lat_16 = 0;
      q_m = '0; q_1 = '0; q_16 = '0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         m_if.in_valid = 1'b0; a1_if.in_valid = 1'b0; a16_if.in_valid = 1'b0;
         if (m_if.out_valid && lat_m == 0) begin lat_m = c; q_m = m_if.out_data; end
         if (a1_if.out_valid && lat_1 == 0) begin lat_1 = c; q_1 = a1_if.out_data; end
         if (a16_if.out_valid && lat_16 == 0) begin lat_16 = c; q_16 = a16_if.out_data; end
      end
      chkn("fips_lat_l4", lat_m, 5);
      chkn("fips_lat_l1", lat_1, 17);
      chkn("fips_lat_l16", lat_16, 2);
      chk("fips_data_l4", q_m, FIPS_OUT);
      chk("fips_data_l1", q_1, FIPS_OUT);
      chk("fips_data_l16", q_16, FIPS_OUT);
      chk("fips_model", model_sub(FIPS_IN), FIPS_OUT);
      chk1("fips_idle_l1", busy_1, 1'b0);
      chk1("fips_idle_l16", busy_16, 1'b0);

      // Every byte value 00..ff, round-tripped through the inverse table
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 16; i++) d[127 - 8*i -: 8] = 8'(16*b + i);
         run_block(d, q, lat);
         chkn("exh_lat", lat, NB + 1);
         chk("exh_roundtrip", inv_state(q), d);
         chk("exh_model", q, model_sub(d));
         if (b == 0)  chk("spot_00", {120'd0, q[127:120]}, 128'h63);
         if (b == 5)  chk("spot_53", {120'd0, q[103:96]}, 128'hed);
         if (b == 15) chk("spot_ff", {120'd0, q[7:0]}, 128'h16);
      end

      // Random blocks
      for (int r = 0; r < 8; r++) begin
         d = rnd128();
         run_block(d, q, lat);
         chkn("rand_lat", lat, NB + 1);
         chk("rand_data", q, model_sub(d));
      end

      // Backpressure in DONE with in_valid toggling
      d = rnd128();
      exp_d = model_sub(d);
      m_if.out_ready = 1'b0;
      m_if.in_valid  = 1'b1;
      m_if.in_data   = d;
      lat = 0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         tick();
         m_if.in_valid = 1'b0;
         if (m_if.out_valid) lat = c;
      end
      chkn("bp_lat", lat, NB + 1);
      for (int i = 0; i < 10; i++) begin
         m_if.in_valid = (i % 2 == 0);
         m_if.in_data  = rnd128();
         tick();
         chk("bp_hold", m_if.out_data, exp_d);
         chk1("bp_in_ready", m_if.in_ready, 1'b0);
         chk1("bp_out_valid", m_if.out_valid, 1'b1);
      end
      m_if.in_valid  = 1'b1;
      m_if.in_data   = rnd128();
      m_if.out_ready = 1'b1;
      tick();
      m_if.in_valid = 1'b0;
      chk1("bp_rel_in_ready", m_if.in_ready, 1'b1);
      chk1("bp_rel_out_valid", m_if.out_valid, 1'b0);
      chk1("bp_rel_busy", busy_m, 1'b0);
      chk("bp_rel_data_held", m_if.out_data, exp_d);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_if.out_valid || busy_m) seen = 1'b1;
      end
      chk1("bp_no_capture", seen, 1'b0);

      // Reset in the second BUSY cycle
      m_if.in_valid = 1'b1;
      m_if.in_data  = rnd128();
      tick();
      m_if.in_valid = 1'b0;
      chk1("mid_busy", busy_m, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("mid_in_ready", m_if.in_ready, 1'b1);
      chk1("mid_out_valid", m_if.out_valid, 1'b0);
      chk1("mid_busy_clr", busy_m, 1'b0);
      chk("mid_out_data", m_if.out_data, '0);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (m_if.out_valid) seen = 1'b1;
      end
      chk1("mid_no_emit", seen, 1'b0);

      // Back-to-back blocks with in_valid and out_ready held high
      for (int i = 0; i < 3; i++) blk[i] = rnd128();
      m_if.in_data   = blk[0];
      m_if.in_valid  = 1'b1;
      m_if.out_ready = 1'b1;
      k = 0;
      nout = 0;
      for (int c = 1; c <= 80 && nout < 3; c++) begin
         acc = m_if.in_ready && m_if.in_valid;
         tick();
         if (acc) begin
            k++;
            if (k < 3) m_if.in_data = blk[k];
            else m_if.in_valid = 1'b0;
         end
         if (m_if.out_valid) begin
            ocyc[nout] = c;
            odat[nout] = m_if.out_data;
            nout++;
         end
      end
      m_if.in_valid = 1'b0;
      chkn("b2b_count", nout, 3);
      if (nout == 3) begin
         for (int i = 0; i < 3; i++) chk("b2b_data", odat[i], model_sub(blk[i]));
         chkn("b2b_space_01", ocyc[1] - ocyc[0], NB + 2);
         chkn("b2b_space_12", ocyc[2] - ocyc[1], NB + 2);
      end
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
